// File: rtl/match_ratio_filter.sv
// -----------------------------------------------------------------------------
// match_ratio_filter
//
// Post-matching ratio-test filter. After the distance-compare stage has filled
// the matched memory with one entry per target descriptor
//   {row[8:0], col[9:0], min[14:0], min2[14:0]}
// this block walks the memory from index 0 to N_TAR-1, keeps the entries whose
// nearest distance is clearly better than the second-nearest
// (min*RATIO_DEN < min2*RATIO_NUM, empty entries excluded) and streams the
// survivors out over a valid/ready handshake.
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   start             one-cycle run request, only looked at while idle
//   busy, done        run in progress / one-cycle end-of-run pulse
//   mem_re, mem_addr  matched-memory read port (synchronous RAM, 1-cycle latency)
//   mem_dout          matched-memory read data
//   match_valid/ready output handshake
//   match_tar_idx,
//   match_row/col/dist accepted match payload (held while stalled)
//   match_count       matches accepted in the current or last run
//
// Every output is a register or a pure decode of the state register, so the
// outputs have no combinational path from any input (in particular from
// match_ready) and all of them clear the instant rst rises.
// -----------------------------------------------------------------------------

// Ratio test for one entry. Products are formed at full 23-bit width so no
// realistic pair of distances can wrap.
module match_ratio_filter_cmp #(
    parameter int RATIO_NUM = 4,
    parameter int RATIO_DEN = 5
) (
    input  logic [14:0] min_i,
    input  logic [14:0] min2_i,
    output logic        pass_o
);
    localparam logic [7:0] NUM8 = RATIO_NUM[7:0];
    localparam logic [7:0] DEN8 = RATIO_DEN[7:0];

    logic [22:0] lhs;
    logic [22:0] rhs;

    assign lhs = {8'd0, min_i}  * {15'd0, DEN8};
    assign rhs = {8'd0, min2_i} * {15'd0, NUM8};

    // min = all ones marks an entry the compare stage never wrote.
    // Strict less-than: a tie is treated as ambiguous and rejected.
    assign pass_o = (min_i != 15'h7FFF) && (lhs < rhs);
endmodule

module match_ratio_filter #(
    parameter int N_TAR     = 256,
    parameter int ADDR_W    = 8,
    parameter int RATIO_NUM = 4,
    parameter int RATIO_DEN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [48:0]       mem_dout,
    output logic              match_valid,
    input  logic              match_ready,
    output logic [ADDR_W-1:0] match_tar_idx,
    output logic [8:0]        match_row,
    output logic [9:0]        match_col,
    output logic [14:0]       match_dist,
    output logic [ADDR_W:0]   match_count
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TAR - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        EV   = 3'd2,
        OUT  = 3'd3,
        FIN  = 3'd4
    } state_t;

    // Layout of one matched-memory word.
    typedef struct packed {
        logic [8:0]  row;
        logic [9:0]  col;
        logic [14:0] min;
        logic [14:0] min2;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   cnt_q,   cnt_d;
    logic [ADDR_W-1:0] idx_q;
    logic [8:0]        row_q;
    logic [9:0]        col_q;
    logic [14:0]       dist_q;
    logic              load_match;
    logic              pass;
    logic              last;
    entry_t            ent;

    assign ent  = entry_t'(mem_dout);
    assign last = (addr_q == LAST_ADDR);

    match_ratio_filter_cmp #(
        .RATIO_NUM (RATIO_NUM),
        .RATIO_DEN (RATIO_DEN)
    ) u_cmp (
        .min_i  (ent.min),
        .min2_i (ent.min2),
        .pass_o (pass)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        load_match = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            // Read is issued here; data is returned for EV.
            RD: state_d = EV;
            EV: begin
                if (pass) begin
                    state_d    = OUT;
                    load_match = 1'b1;
                    cnt_d      = cnt_q + (ADDR_W+1)'(1);
                end else if (last) begin
                    state_d = FIN;
                end else begin
                    state_d = RD;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            // Payload registers stay untouched until the handshake completes.
            OUT: begin
                if (match_ready) begin
                    if (last) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            dist_q <= '0;
        end else if (load_match) begin
            idx_q  <= addr_q;
            row_q  <= ent.row;
            col_q  <= ent.col;
            dist_q <= ent.min;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    // addr_q only moves on the transition into RD (or to 0 on start), so
    // driving it straight out gives the "hold last value outside RD" behaviour.
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FIN);
    assign mem_re        = (state_q == RD);
    assign mem_addr      = addr_q;
    assign match_valid   = (state_q == OUT);
    assign match_tar_idx = idx_q;
    assign match_row     = row_q;
    assign match_col     = col_q;
    assign match_dist    = dist_q;
    assign match_count   = cnt_q;
endmodule
